// File: rtl/gcd_binary_unit.sv
// rtl/gcd_binary_unit.sv - binary (Stein) GCD unit with valid/ready handshakes and cycle count
// Operands load in IDLE, one reduction step per CALC cycle, result held in DONE until taken.
module gcd_binary_unit #(
  parameter int W  = 16,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  operands_bits_A,
  input  logic [W-1:0]  operands_bits_B,
  input  logic          operands_val,
  output logic          operands_rdy,
  output logic [W-1:0]  result_bits_data,
  output logic [CW-1:0] result_bits_cycles,
  output logic          result_val,
  input  logic          result_rdy
);

  localparam int KW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_n;
  logic [W-1:0]  a, a_n, b, b_n, res, res_n;
  logic [KW-1:0] k, k_n;
  logic [CW-1:0] cnt, cnt_n, cyc, cyc_n, cnt_inc;

  // Count saturates rather than wrapping so an oversized run never reports a small number.
  assign cnt_inc = (&cnt) ? cnt : cnt + CW'(1);

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    k_n     = k;
    cnt_n   = cnt;
    res_n   = res;
    cyc_n   = cyc;
    case (state)
      IDLE: begin
        if (operands_val) begin
          a_n     = operands_bits_A;
          b_n     = operands_bits_B;
          k_n     = '0;
          cnt_n   = '0;
          state_n = CALC;
        end
      end
      CALC: begin
        cnt_n = cnt_inc;
        if (a == '0) begin
          res_n   = b << k;
          cyc_n   = cnt_inc;
          state_n = DONE;
        end else if (b == '0) begin
          res_n   = a << k;
          cyc_n   = cnt_inc;
          state_n = DONE;
        end else if (!a[0] && !b[0]) begin
          a_n = a >> 1;
          b_n = b >> 1;
          k_n = k + KW'(1);
        end else if (!a[0]) begin
          a_n = a >> 1;
        end else if (!b[0]) begin
          b_n = b >> 1;
        end else if (a >= b) begin
          a_n = (a - b) >> 1;
        end else begin
          b_n = (b - a) >> 1;
        end
      end
      DONE: begin
        if (result_rdy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      k     <= '0;
      cnt   <= '0;
      res   <= '0;
      cyc   <= '0;
    end else begin
      state <= state_n;
      a     <= a_n;
      b     <= b_n;
      k     <= k_n;
      cnt   <= cnt_n;
      res   <= res_n;
      cyc   <= cyc_n;
    end
  end

  assign operands_rdy       = (state == IDLE);
  assign result_val         = (state == DONE);
  assign result_bits_data   = res;
  assign result_bits_cycles = cyc;

endmodule

// File: tb/tb_gcd_binary_unit.sv
// tb/tb_gcd_binary_unit.sv - self-checking bench for gcd_binary_unit
// Vector table plus hold, reset-abort and random sequences against a Euclid reference.
module tb_gcd_binary_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] op_a, op_b;
  logic        op_val;
  logic        op_rdy;
  logic [15:0] res_data;
  logic [5:0]  res_cycles;
  logic        res_val;
  logic        res_rdy;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic [5:0]  c;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [5:0]  c;
    bit          chk_c;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  gcd_binary_unit #(.W(16), .CW(6)) dut (
    .clk               (clk),
    .reset             (reset),
    .operands_bits_A   (op_a),
    .operands_bits_B   (op_b),
    .operands_val      (op_val),
    .operands_rdy      (op_rdy),
    .result_bits_data  (res_data),
    .result_bits_cycles(res_cycles),
    .result_val        (res_val),
    .result_rdy        (res_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [15:0] ref_gcd(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Loads one pair, waits for the result and checks it against the scoreboard head.
  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] d,
                     input logic [5:0] c, input bit chk_c, input int hold);
    exp_t e;
    int   n;
    check("rdy_before_load", op_rdy, 1);
    op_a    = a;
    op_b    = b;
    op_val  = 1'b1;
    res_rdy = (hold == 0);
    tick();
    op_val = 1'b0;
    sb.push_back('{d: d, c: c, chk_c: chk_c});
    n = 0;
    while (!res_val && n < 200) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    if (!res_val) begin
      total++;
      $display("FAIL timeout: no result_val for A=%0d B=%0d within 200 cycles", a, b);
      return;
    end
    check("data", res_data, e.d);
    if (e.chk_c) begin
      check("cycles", res_cycles, e.c);
      check("latency", n, e.c);
    end else begin
      check("cycle_bound", res_cycles <= 6'd33, 1);
    end
    for (int i = 0; i < hold; i++) begin
      op_val = 1'b1;
      op_a   = 16'($urandom);
      op_b   = 16'($urandom);
      tick();
      check("hold_val", res_val, 1);
      check("hold_data", res_data, e.d);
      check("hold_cycles", res_cycles, e.c);
      check("hold_rdy", op_rdy, 0);
    end
    op_val  = 1'b0;
    res_rdy = 1'b1;
    tick();
    check("val_one_cycle", res_val, 0);
    check("back_idle", op_rdy, 1);
  endtask

  initial begin
    vecs[0] = '{a: 16'd12,    b: 16'd18,  d: 16'd6,  c: 6'd5};
    vecs[1] = '{a: 16'd65535, b: 16'd1,   d: 16'd1,  c: 6'd17};
    vecs[2] = '{a: 16'd0,     b: 16'd0,   d: 16'd0,  c: 6'd1};
    vecs[3] = '{a: 16'd7,     b: 16'd0,   d: 16'd7,  c: 6'd1};
    vecs[4] = '{a: 16'd0,     b: 16'd9,   d: 16'd9,  c: 6'd1};
    vecs[5] = '{a: 16'd1,     b: 16'd1,   d: 16'd1,  c: 6'd2};
    vecs[6] = '{a: 16'd8,     b: 16'd4,   d: 16'd4,  c: 6'd5};
    vecs[7] = '{a: 16'd21,    b: 16'd14,  d: 16'd7,  c: 6'd4};

    reset   = 1'b1;
    op_a    = '0;
    op_b    = '0;
    op_val  = 1'b0;
    res_rdy = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_rdy", op_rdy, 1);
    check("reset_val", res_val, 0);
    check("reset_data", res_data, 0);
    check("reset_cycles", res_cycles, 0);

    foreach (vecs[i]) run(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].c, 1'b1, 0);

    run(16'd48, 16'd180, 16'd12, 6'd9, 1'b1, 10);

    // Abort mid-calculation: the pending gcd(1000,250) must never appear.
    op_a   = 16'd1000;
    op_b   = 16'd250;
    op_val = 1'b1;
    res_rdy = 1'b1;
    tick();
    op_val = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_rdy", op_rdy, 1);
    check("abort_val", res_val, 0);
    check("abort_data", res_data, 0);
    check("abort_cycles", res_cycles, 0);
    run(16'd21, 16'd14, 16'd7, 6'd4, 1'b1, 0);

    for (int i = 0; i < 800; i++) begin
      logic [15:0] ra, rb;
      case (i % 4)
        0: begin ra = 16'($urandom); rb = 16'($urandom); end
        1: begin ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255)); end
        2: begin ra = 16'($urandom) << $urandom_range(0, 8); rb = 16'($urandom) << $urandom_range(0, 8); end
        default: begin ra = 16'($urandom); rb = 16'($urandom_range(0, 3)); end
      endcase
      run(ra, rb, ref_gcd(ra, rb), 6'd0, 1'b0, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
